// File: rtl/pe_relay_ws.sv
// pe_relay_ws: west/south relay tile for the PE grid.
// Each direction is an independent valid/ready channel with a small FIFO,
// so a stalled neighbour never causes a word to be dropped. Egress is
// gated by the tile-level ap_start; ingress keeps filling while it is low.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ap_start              egress enable (no word leaves while low)
//   in_from_west[_valid/_ready]   west ingress handshake
//   out_to_west[_valid/_ready]    west egress handshake (FIFO head)
//   in_from_south[_valid/_ready]  south ingress handshake
//   out_to_south[_valid/_ready]   south egress handshake (FIFO head)
//   west_level, south_level       FIFO occupancy, 0..2**FIFO_DEPTH_LOG2
//
// Optional macro PE_RELAY_STATS_EN adds west_xfer_cnt / south_xfer_cnt,
// saturating 32-bit counts of egress pops per channel.

module pe_relay_ws_fifo #(
  parameter int WIDTH      = 130,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Ready looks only at registered occupancy: a pop in a full cycle does
  // not open a slot until the following cycle.
  assign in_ready  = (level != LEVEL_FULL);
  assign out_valid = ap_start && (level != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      // Storage is cleared so the head read is never X after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end
endmodule

module pe_relay_ws #(
  parameter int WEST_WIDTH      = 130,
  parameter int SOUTH_WIDTH     = 130,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ap_start,
  input  logic [WEST_WIDTH-1:0]       in_from_west,
  input  logic                        in_from_west_valid,
  output logic                        in_from_west_ready,
  output logic [WEST_WIDTH-1:0]       out_to_west,
  output logic                        out_to_west_valid,
  input  logic                        out_to_west_ready,
  input  logic [SOUTH_WIDTH-1:0]      in_from_south,
  input  logic                        in_from_south_valid,
  output logic                        in_from_south_ready,
  output logic [SOUTH_WIDTH-1:0]      out_to_south,
  output logic                        out_to_south_valid,
  input  logic                        out_to_south_ready,
`ifdef PE_RELAY_STATS_EN
  output logic [31:0]                 west_xfer_cnt,
  output logic [31:0]                 south_xfer_cnt,
`endif
  output logic [FIFO_DEPTH_LOG2:0]    west_level,
  output logic [FIFO_DEPTH_LOG2:0]    south_level
);

  pe_relay_ws_fifo #(.WIDTH(WEST_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_west (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_from_west),
    .in_valid  (in_from_west_valid),
    .in_ready  (in_from_west_ready),
    .out_data  (out_to_west),
    .out_valid (out_to_west_valid),
    .out_ready (out_to_west_ready),
    .level     (west_level)
  );

  pe_relay_ws_fifo #(.WIDTH(SOUTH_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_south (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_from_south),
    .in_valid  (in_from_south_valid),
    .in_ready  (in_from_south_ready),
    .out_data  (out_to_south),
    .out_valid (out_to_south_valid),
    .out_ready (out_to_south_ready),
    .level     (south_level)
  );

`ifdef PE_RELAY_STATS_EN
  logic west_pop;
  logic south_pop;

  assign west_pop  = out_to_west_valid && out_to_west_ready;
  assign south_pop = out_to_south_valid && out_to_south_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      west_xfer_cnt  <= '0;
      south_xfer_cnt <= '0;
    end else begin
      if (west_pop && (west_xfer_cnt != '1))   west_xfer_cnt  <= west_xfer_cnt + 32'd1;
      if (south_pop && (south_xfer_cnt != '1)) south_xfer_cnt <= south_xfer_cnt + 32'd1;
    end
  end
`endif

endmodule
